jtkcpu_shifter: RTL



---
 rtl/jtkcpu_shifter_if.sv | 29 ++
 rtl/jtkcpu_shifter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/jtkcpu_shifter_if.sv
// jtkcpu_shifter_if: request/result bundle between a shift requester (master) and jtkcpu_shifter (slave).
interface jtkcpu_shifter_if #(
    parameter int W  = 16,
    parameter int CW = 8
);
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] cnt;
    logic [W-1:0]  din;
    logic          cin;
    logic          vin;
    logic          busy;
    logic          done;
    logic [W-1:0]  dout;
    logic          c_out;
    logic          v_out;
    logic          n_out;
    logic          z_out;

    modport master (
        output start, mode, cnt, din, cin, vin,
        input  busy, done, dout, c_out, v_out, n_out, z_out
    );

    modport slave (
        input  start, mode, cnt, din, cin, vin,
        output busy, done, dout, c_out, v_out, n_out, z_out
    );
endinterface

// File: rtl/jtkcpu_shifter.sv
// jtkcpu_shifter: one-bit-per-cen shift/rotate engine with C/V/N/Z flags.
// Define JTKCPU_SHIFTER_BARREL_EN for a single-cycle variant with identical results.
module jtkcpu_shifter #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              cen_i,
    jtkcpu_shifter_if.slave   bus
);
    localparam logic [2:0] LSR = 3'd0, ASR = 3'd1, ASL = 3'd2, ROR = 3'd3, ROL = 3'd4;

    typedef struct packed {
        logic [W-1:0] acc;
        logic         c;
        logic         v;
    } st_t;

    // ROR/ROL treat {c,acc} as one (W+1)-bit ring; modes 5-7 fall through unchanged
    function automatic st_t step(st_t s, logic [2:0] m);
        st_t r;
        r = s;
        if (m == LSR || m == ASR) begin
            r.acc = {m == ASR && s.acc[W-1], s.acc[W-1:1]};
            r.c   = s.acc[0];
        end else if (m == ROR) begin
            r.acc = {s.c, s.acc[W-1:1]};
            r.c   = s.acc[0];
        end else if (m == ASL || m == ROL) begin
            r.acc = {s.acc[W-2:0], m == ROL && s.c};
            r.c   = s.acc[W-1];
            r.v   = s.v | (s.acc[W-1] ^ s.acc[W-2]);
        end
        return r;
    endfunction

    st_t          fin_s;
    logic         fin;
    logic         done_q;
    logic [W-1:0] dout_q;
    logic [3:0]   flags_q;

`ifdef JTKCPU_SHIFTER_BARREL_EN
    logic [31:0] n_steps;
    logic [31:0] eff;

    // Past W steps shifts are settled one step later; rotations keep a full period so sticky V sees every pair
    always_comb begin
        fin_s   = {bus.din, bus.cin, bus.vin};
        n_steps = 32'(bus.cnt);
        eff     = (n_steps <= W) ? n_steps :
                  (bus.mode == ROR || bus.mode == ROL) ? W + 1 + n_steps % (W + 1) : W + 1;
        for (int i = 0; i < 2 * W + 1; i++)
            if (i < eff) fin_s = step(fin_s, bus.mode);
    end

    assign fin      = bus.start;
    assign bus.busy = 1'b0;
`else
    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    st_t           st_q, st_d, nxt;
    logic [2:0]    mode_q, mode_d;
    logic [CW-1:0] rem_q, rem_d;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            mode_q  <= '0;
            rem_q   <= '0;
        end else if (cen_i) begin
            state_q <= state_d;
            st_q    <= st_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end

    always_comb begin
        nxt     = step(st_q, mode_q);
        state_d = state_q;
        st_d    = st_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        fin     = 1'b0;
        fin_s   = nxt;
        if (state_q == IDLE && bus.start) begin
            st_d    = {bus.din, bus.cin, bus.vin};
            mode_d  = bus.mode;
            rem_d   = bus.cnt;
            fin     = bus.cnt == '0;
            fin_s   = st_d;
            state_d = fin ? IDLE : RUN;
        end else if (state_q == RUN) begin
            st_d    = nxt;
            rem_d   = rem_q - CW'(1);
            fin     = rem_q == CW'(1);
            state_d = fin ? IDLE : RUN;
        end
    end

    assign bus.busy = state_q == RUN;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            done_q  <= 1'b0;
            dout_q  <= '0;
            flags_q <= '0;
        end else if (cen_i) begin
            done_q <= fin;
            if (fin) begin
                dout_q  <= fin_s.acc;
                flags_q <= {fin_s.c, fin_s.v, fin_s.acc[W-1], fin_s.acc == '0};
            end
        end

    assign bus.done  = done_q;
    assign bus.dout  = dout_q;
    assign bus.c_out = flags_q[3];
    assign bus.v_out = flags_q[2];
    assign bus.n_out = flags_q[1];
    assign bus.z_out = flags_q[0];
endmodule
